// File: rtl/lut_sweeper_pkg.sv
// lut_sweeper_pkg
//   Shared definitions for the LUT sweeper: controller state encoding and
//   the legal range of the input-count parameter N_IN.
package lut_sweeper_pkg;

  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lut_sweeper_if.sv
// lut_sweeper_if
//   Bundles the configuration, evaluation and sweep signals of lut_sweeper.
//   Parameter N_IN sets the input-vector width; truth tables are 2**N_IN bits.
//   Modports:
//     slave  - the lut_sweeper side (consumes cfg/eval/start, drives results)
//     master - the user side (drives cfg/eval/start, observes results)
interface lut_sweeper_if #(
  parameter int N_IN = 3
);

  logic                 cfg_we;
  logic [2**N_IN-1:0]   cfg_tt;
  logic [N_IN-1:0]      eval_in;
  logic                 eval_y;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [N_IN-1:0]      sweep_idx;
  logic [2**N_IN-1:0]   sweep_tt;
  logic [N_IN:0]        ones_cnt;

  modport slave (
    input  cfg_we, cfg_tt, eval_in, start,
    output eval_y, busy, done, sweep_idx, sweep_tt, ones_cnt
  );

  modport master (
    output cfg_we, cfg_tt, eval_in, start,
    input  eval_y, busy, done, sweep_idx, sweep_tt, ones_cnt
  );

endinterface

// File: rtl/lut_core.sv
// lut_core
//   Truth-table storage for an N_IN-input boolean function.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset (table <= RESET_TT)
//     we, wdata - table write strobe and new table contents
//     idx, y    - live index and its registered table output (1-cycle latency)
//     ridx, rbit- combinational read port used by the sweep controller
module lut_core #(
  parameter int                 N_IN     = 3,
  parameter logic [2**N_IN-1:0] RESET_TT = 8'h3F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [2**N_IN-1:0]   wdata,
  input  logic [N_IN-1:0]      idx,
  output logic                 y,
  input  logic [N_IN-1:0]      ridx,
  output logic                 rbit
);

  logic [2**N_IN-1:0] table_q;
  logic               y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      table_q <= RESET_TT;
      y_q     <= 1'b0;
    end else begin
      if (we) begin
        table_q <= wdata;
      end
      // Reads the table as it stood before this edge's write.
      y_q <= table_q[idx];
    end
  end

  assign y    = y_q;
  assign rbit = table_q[ridx];

endmodule

// File: rtl/lut_sweeper.sv
// lut_sweeper
//   Programmable N_IN-input lookup table with a registered live output and an
//   exhaustive sweep engine that walks every index, captures the table and
//   counts its true minterms.
//   Ports:
//     clk - clock, all state updates on the rising edge
//     rst - asynchronous active-high reset
//     bus - lut_sweeper_if.slave: cfg_we/cfg_tt (table write, IDLE only),
//           eval_in/eval_y (live evaluation), start/busy/done (sweep control),
//           sweep_idx/sweep_tt/ones_cnt (sweep results)
module lut_sweeper
  import lut_sweeper_pkg::*;
#(
  parameter int                 N_IN     = 3,
  parameter logic [2**N_IN-1:0] RESET_TT = 8'h3F
) (
  input  logic         clk,
  input  logic         rst,
  lut_sweeper_if.slave bus
);

  localparam int TT_W = 2**N_IN;
  localparam logic [N_IN-1:0] IDX_ONE  = 1;
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("lut_sweeper: N_IN out of range");
  end

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic              tbl_we;
  logic              sweep_bit;

  // Writes land only in IDLE; a write together with start still lands, and
  // the sweep reads the new table because it begins on the following edge.
  assign tbl_we = bus.cfg_we && (state_q == IDLE);

  lut_core #(
    .N_IN     (N_IN),
    .RESET_TT (RESET_TT)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .wdata (bus.cfg_tt),
    .idx   (bus.eval_in),
    .y     (bus.eval_y),
    .ridx  (idx_q),
    .rbit  (sweep_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tt_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tt_d    = tt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SWEEP;
          idx_d   = '0;
          tt_d    = '0;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        tt_d[idx_q] = sweep_bit;
        // N_IN+1 bits hold the full 2**N_IN count, so no saturation needed.
        cnt_d = cnt_q + {{N_IN{1'b0}}, sweep_bit};
        // Natural N_IN-bit wrap returns the index to 0 on the last step.
        idx_d = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q == SWEEP);
  assign bus.done      = (state_q == DONE);
  assign bus.sweep_idx = idx_q;
  assign bus.sweep_tt  = tt_q;
  assign bus.ones_cnt  = cnt_q;

endmodule

// File: doc/lut_sweeper.md
LUT_SWEEPER -- requirements
Module: lut_sweeper

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, meaning the number of boolean inputs, legal range 1..8.
REQ-002 The block SHALL have parameter RESET_TT, width 2**N_IN, default 8'h3F, meaning the truth table loaded on reset; bit i is the output for input vector i.
REQ-003 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port cfg_we  input  1  truth-table write strobe.
REQ-006 Port cfg_tt  input  2**N_IN  new truth table, sampled when cfg_we=1.
REQ-007 Port eval_in  input  N_IN  live input vector, with eval_in[N_IN-1] as the MSB of the table index.
REQ-008 Port eval_y  output  1  registered function output for eval_in.
REQ-009 Port start  input  1  request for an exhaustive sweep.
REQ-010 Port busy  output  1  high while a sweep is in progress.
REQ-011 Port done  output  1  single-cycle pulse marking sweep completion.
REQ-012 Port sweep_idx  output  N_IN  current sweep index.
REQ-013 Port sweep_tt  output  2**N_IN  truth table captured by the sweep.
REQ-014 Port ones_cnt  output  N_IN+1  count of true minterms found by the sweep.

Function
REQ-015 eval_y SHALL equal table[eval_in] registered, giving 1-cycle latency, and SHALL be updated every cycle, including during a sweep.
REQ-016 A write with cfg_we=1 SHALL update the table at that edge only in IDLE, and SHALL be ignored in SWEEP and DONE.
REQ-017 The FSM SHALL have exactly three states: IDLE, SWEEP and DONE.
REQ-018 IDLE->SWEEP SHALL occur on an edge with start=1; at that edge sweep_idx:=0, sweep_tt:=0 and ones_cnt:=0.
REQ-019 When start and cfg_we are both high in IDLE, the SHALL write the new table and accept the sweep at the same edge, and the sweep SHALL use the new table.
REQ-020 Each SWEEP edge SHALL perform sweep_tt[sweep_idx]:=table[sweep_idx], add ones_cnt+=table[sweep_idx] and increment sweep_idx.
REQ-021 SWEEP->DONE SHALL occur on the edge that processes index 2**N_IN-1; sweep_idx SHALL wrap to 0 at that edge.
REQ-022 busy SHALL be high for exactly 2**N_IN cycles, namely the cycles the FSM spends in SWEEP.
REQ-023 The DONE state SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 start SHALL be ignored in SWEEP and DONE, with no queuing.
REQ-025 sweep_tt and ones_cnt SHALL hold their values after DONE until the next accepted start.
REQ-026 ones_cnt SHALL NOT overflow; its maximum value is 2**N_IN.

Reset
REQ-027 When rst is asserted, the block SHALL immediately apply: table=RESET_TT, state=IDLE, busy=0, done=0, sweep_idx=0, sweep_tt=0, ones_cnt=0 and eval_y=0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no done pulse and SHALL restore RESET_TT, discarding any loaded table.
REQ-029 The first edge after reset deassertion SHALL be able to accept start or cfg_we.

Structure
REQ-030 The state enum (IDLE/SWEEP/DONE) and the N_IN range limits SHALL live in a shared package named lut_sweeper_pkg.
REQ-031 Table storage plus the registered eval_y read SHALL form one sub-module named lut_core, with ports clk, rst, we, wdata, idx and y; lut_core SHALL also expose a combinational read at the sweep index.
REQ-032 The FSM, counters and capture register SHALL reside in lut_sweeper.

Verification
REQ-033 Scenario: rst pulse, then eval_in stepped 0..7 -> eval_y = 1,1,1,1,1,1,0,0, each appearing one cycle after its eval_in value.
REQ-034 Scenario: start after reset -> busy high for 8 cycles; done pulses on cycle 9; sweep_tt=8'h3F; ones_cnt=6.
REQ-035 Scenario: cfg_we with cfg_tt=8'h96 in the same cycle as start -> sweep_tt=8'h96, ones_cnt=4.
REQ-036 Scenario: cfg_we with 8'hFF while busy, then a second sweep -> the second sweep reports 8'h3F and ones_cnt=6, showing the write was ignored.
REQ-037 Scenario: rst asserted at sweep index 4 -> busy=0 immediately; no done pulse; sweep_tt=0; the table equals 8'h3F.
REQ-038 Scenario: N_IN=4, table 16'hFFFF, one sweep -> busy high for 16 cycles, ones_cnt=16 with no wrap; start pulses during busy produce no second sweep.
